// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and default bus widths.
package dmem_pkg;

    localparam int DMEM_AW    = 32;
    localparam int DMEM_DW    = 32;
    localparam int DMEM_DEPTH = 206;

    // Requester indices; also the encoding of the latched owner bit.
    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port of the
// data-memory arbiter. The slave modport is the arbiter's view; the master
// modport is the environment (requesters plus the memory array).
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);

    // Requester 0 (CPU load/store stage)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    logic          err0;

    // Requester 1 (DMA/debug loader)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    logic          err1;

    // Single-ported data memory
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output gnt0, ack0, rdata0, err0,
        output gnt1, ack1, rdata1, err1,
        output mem_addr, mem_din, mem_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  gnt0, ack0, rdata0, err0,
        input  gnt1, ack1, rdata1, err1,
        input  mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-input request picker. Produces a one-hot (or empty) grant vector.
// A lone request always wins; on a tie, port 0 wins when FIXED_PRIO is
// non-zero, otherwise the port that was not granted last wins.
module dmem_rr_pick #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    output logic [1:0] o_gnt
);

    // Select the winner among the active requests.
    always_comb begin
        // NOTE: o_gnt gets a default before any branch so no path leaves it unassigned (no latch).
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            if ((FIXED_PRIO != 0) || i_rr_last) begin
                o_gnt = 2'b01;
            end else begin
                o_gnt = 2'b10;
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Port 0 is the CPU load/store stage, port 1 the DMA/debug loader.
// Each access runs IDLE (grant, latch request) -> ACCESS (drive memory)
// -> ack/rdata one cycle later, giving one access every two cycles.
// Optional feature: define DMEM_ADDR_CHECK_EN to reject addresses >= DEPTH
// (write suppressed, err pulsed with ack, read data forced to 0).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

`ifdef DMEM_ADDR_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    state_t        r_state;
    logic          r_rr_last;
    logic          r_owner;
    logic          r_we;
    logic          r_oob;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_we;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_sel;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_oob;

    assign w_req = {bus.req1, bus.req0};

    dmem_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req     (w_req),
        .i_rr_last (r_rr_last),
        .o_gnt     (w_pick)
    );

    // Grants are offered only in IDLE and never while reset is asserted.
    assign w_gnt       = ((r_state == ST_IDLE) && reset) ? w_pick : 2'b00;
    assign w_sel       = w_pick[1];
    assign w_sel_we    = w_sel ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;
    assign w_oob       = CHECK_EN && (w_sel_addr >= AW'(DEPTH));

    // Access sequencer: latch the winner in IDLE, drive memory in ACCESS,
    // then return ack/err/rdata to the owner on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rr_last  <= 1'b1;
            r_owner    <= P_CPU;
            r_we       <= 1'b0;
            r_oob      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_owner    <= w_sel;
                        r_we       <= w_sel_we;
                        r_oob      <= w_oob;
                        r_mem_addr <= w_sel_addr;
                        r_mem_din  <= w_sel_wdata;
                        r_mem_we   <= w_sel_we && !w_oob;
                        r_rr_last  <= w_sel;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                    if (r_owner == P_CPU) begin
                        r_ack0 <= 1'b1;
                        r_err0 <= r_oob;
                        if (!r_we) begin
                            r_rdata0 <= r_oob ? '0 : bus.mem_dout;
                        end
                    end else begin
                        r_ack1 <= 1'b1;
                        r_err1 <= r_oob;
                        if (!r_we) begin
                            r_rdata1 <= r_oob ? '0 : bus.mem_dout;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt0     = w_gnt[0];
    assign bus.gnt1     = w_gnt[1];
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.err0     = r_err0;
    assign bus.err1     = r_err1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_we   = r_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Instance a is round-robin, instance b is
// fixed-priority; each has its own small memory (preloaded to A000_0000|addr
// while reset is low, written on posedge, DOut updated on negedge).
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus_a ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus_b ();

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(206), .FIXED_PRIO(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(206), .FIXED_PRIO(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_din;
        end
    end
    always @(negedge clk) bus_a.mem_dout <= mem_a[bus_a.mem_addr[7:0]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus_b.mem_we) begin
            mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_din;
        end
    end
    always @(negedge clk) bus_b.mem_dout <= mem_b[bus_b.mem_addr[7:0]];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd1; bus_a.wdata0 = 32'h0;
        bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 32'd2; bus_a.wdata1 = 32'h0;
        bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 32'd3; bus_b.wdata0 = 32'h0;
        bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 32'd4; bus_b.wdata1 = 32'h0;
        repeat (3) cyc();
        smp();
        total++;
        if ({bus_a.gnt0, bus_a.gnt1, bus_a.ack0, bus_a.ack1, bus_a.err0, bus_a.err1, bus_a.mem_we} !== 7'b0) begin
            bad++;
            $display("FAIL rst_ctrl got=%b exp=0000000", {bus_a.gnt0, bus_a.gnt1, bus_a.ack0, bus_a.ack1, bus_a.err0, bus_a.err1, bus_a.mem_we});
        end
        total++;
        if ({bus_a.mem_addr, bus_a.mem_din} !== 64'h0) begin
            bad++;
            $display("FAIL rst_mem_bus got=%h exp=0", {bus_a.mem_addr, bus_a.mem_din});
        end
        total++;
        if ({bus_a.rdata0, bus_a.rdata1} !== 64'h0) begin
            bad++;
            $display("FAIL rst_rdata got=%h exp=0", {bus_a.rdata0, bus_a.rdata1});
        end
    endtask

    // Both ports held high from reset release: grants 0,1,0,1.
    task automatic test_round_robin();
        logic [31:0] exp_rd1;
        logic        p;
        exp_rd1 = 32'h0;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p = (k % 2 == 1);
            smp();
            total++;
            if ({bus_a.gnt1, bus_a.gnt0} !== (p ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, {bus_a.gnt1, bus_a.gnt0}, (p ? 2'b10 : 2'b01));
            end
            if (k > 0) begin
                if (p) begin
                    total++;
                    if ({bus_a.ack1, bus_a.ack0, bus_a.rdata0} !== {2'b01, 32'hA000_0001}) begin
                        bad++;
                        $display("FAIL rr_ack0 k=%0d got=%h exp=%h", k, {bus_a.ack1, bus_a.ack0, bus_a.rdata0}, {2'b01, 32'hA000_0001});
                    end
                    total++;
                    if (bus_a.rdata1 !== exp_rd1) begin
                        bad++;
                        $display("FAIL rr_rdata1_held k=%0d got=%h exp=%h", k, bus_a.rdata1, exp_rd1);
                    end
                end else begin
                    exp_rd1 = 32'hA000_0002;
                    total++;
                    if ({bus_a.ack1, bus_a.ack0, bus_a.rdata1} !== {2'b10, exp_rd1}) begin
                        bad++;
                        $display("FAIL rr_ack1 k=%0d got=%h exp=%h", k, {bus_a.ack1, bus_a.ack0, bus_a.rdata1}, {2'b10, exp_rd1});
                    end
                end
            end
            cyc();
            smp();
            total++;
            if ({bus_a.gnt1, bus_a.gnt0, bus_a.mem_addr} !== {2'b00, (p ? 32'd2 : 32'd1)}) begin
                bad++;
                $display("FAIL rr_access k=%0d got=%h exp=%h", k, {bus_a.gnt1, bus_a.gnt0, bus_a.mem_addr}, {2'b00, (p ? 32'd2 : 32'd1)});
            end
            if (k == 3) begin
                bus_a.req0 = 1'b0;
                bus_a.req1 = 1'b0;
            end
            cyc();
        end
        smp();
        total++;
        if ({bus_a.ack1, bus_a.ack0, bus_a.gnt1, bus_a.gnt0, bus_a.rdata1} !== {4'b1000, 32'hA000_0002}) begin
            bad++;
            $display("FAIL rr_last_ack got=%h exp=%h", {bus_a.ack1, bus_a.ack0, bus_a.gnt1, bus_a.gnt0, bus_a.rdata1}, {4'b1000, 32'hA000_0002});
        end
    endtask

    task automatic test_write_read();
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b1; bus_a.addr0 = 32'd5; bus_a.wdata0 = 32'hDEAD_BEEF;
        smp();
        total++;
        if ({bus_a.gnt0, bus_a.gnt1, bus_a.mem_we} !== 3'b100) begin
            bad++;
            $display("FAIL wr_cycleN got=%b exp=100", {bus_a.gnt0, bus_a.gnt1, bus_a.mem_we});
        end
        cyc();
        bus_a.req0 = 1'b0;
        smp();
        total++;
        if ({bus_a.gnt0, bus_a.mem_we, bus_a.ack0, bus_a.mem_addr, bus_a.mem_din} !== {3'b010, 32'd5, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL wr_access got=%h exp=%h", {bus_a.gnt0, bus_a.mem_we, bus_a.ack0, bus_a.mem_addr, bus_a.mem_din}, {3'b010, 32'd5, 32'hDEAD_BEEF});
        end
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd5;
        smp();
        total++;
        if ({bus_a.ack0, bus_a.err0, bus_a.mem_we, bus_a.gnt0} !== 4'b1001) begin
            bad++;
            $display("FAIL wr_ack_and_rd_gnt got=%b exp=1001", {bus_a.ack0, bus_a.err0, bus_a.mem_we, bus_a.gnt0});
        end
        cyc();
        bus_a.req0 = 1'b0;
        smp();
        total++;
        if ({bus_a.mem_we, bus_a.ack0, bus_a.gnt0} !== 3'b000) begin
            bad++;
            $display("FAIL rd_access got=%b exp=000", {bus_a.mem_we, bus_a.ack0, bus_a.gnt0});
        end
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.err0, bus_a.rdata0} !== {2'b10, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd_ack got=%h exp=%h", {bus_a.ack0, bus_a.err0, bus_a.rdata0}, {2'b10, 32'hDEAD_BEEF});
        end
        total++;
        if (bus_a.rdata1 !== 32'hA000_0002) begin
            bad++;
            $display("FAIL rd_rdata1_held got=%h exp=a0000002", bus_a.rdata1);
        end
    endtask

    // Port-1 read granted in the same cycle port 0 receives its ack.
    task automatic test_back_to_back();
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd4;
        smp();
        total++;
        if ({bus_a.gnt1, bus_a.gnt0} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_gnt0 got=%b exp=01", {bus_a.gnt1, bus_a.gnt0});
        end
        cyc();
        bus_a.req0 = 1'b0;
        cyc();
        bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 32'd3;
        smp();
        total++;
        if ({bus_a.ack0, bus_a.gnt1, bus_a.gnt0, bus_a.rdata0} !== {3'b110, 32'hA000_0004}) begin
            bad++;
            $display("FAIL b2b_ack0_gnt1 got=%h exp=%h", {bus_a.ack0, bus_a.gnt1, bus_a.gnt0, bus_a.rdata0}, {3'b110, 32'hA000_0004});
        end
        cyc();
        bus_a.req1 = 1'b0;
        smp();
        total++;
        if ({bus_a.gnt1, bus_a.gnt0, bus_a.ack1} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_access got=%b exp=000", {bus_a.gnt1, bus_a.gnt0, bus_a.ack1});
        end
        cyc();
        smp();
        total++;
        if ({bus_a.ack1, bus_a.ack0, bus_a.rdata1, bus_a.rdata0} !== {2'b10, 32'hA000_0003, 32'hA000_0004}) begin
            bad++;
            $display("FAIL b2b_ack1 got=%h exp=%h", {bus_a.ack1, bus_a.ack0, bus_a.rdata1, bus_a.rdata0}, {2'b10, 32'hA000_0003, 32'hA000_0004});
        end
    endtask

    task automatic test_reset_mid_access();
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b1; bus_a.addr0 = 32'd7; bus_a.wdata0 = 32'h1234_5678;
        cyc();
        bus_a.req0 = 1'b0;
        smp();
        total++;
        if (bus_a.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_we got=%b exp=1", bus_a.mem_we);
        end
        #1;
        reset = 1'b0;
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd1;
        bus_a.req1 = 1'b1; bus_a.we1 = 1'b0; bus_a.addr1 = 32'd2;
        #1;
        total++;
        if ({bus_a.mem_we, bus_a.gnt0, bus_a.gnt1, bus_a.ack0, bus_a.ack1, bus_a.mem_addr, bus_a.mem_din, bus_a.rdata0} !== 101'h0) begin
            bad++;
            $display("FAIL mid_async_clear got=%h exp=0", {bus_a.mem_we, bus_a.gnt0, bus_a.gnt1, bus_a.ack0, bus_a.ack1, bus_a.mem_addr, bus_a.mem_din, bus_a.rdata0});
        end
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.gnt0, bus_a.gnt1, bus_a.mem_we} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_no_ack got=%b exp=0000", {bus_a.ack0, bus_a.gnt0, bus_a.gnt1, bus_a.mem_we});
        end
        cyc();
        reset = 1'b1;
        smp();
        total++;
        if ({bus_a.gnt1, bus_a.gnt0} !== 2'b01) begin
            bad++;
            $display("FAIL mid_first_tie got=%b exp=01", {bus_a.gnt1, bus_a.gnt0});
        end
        cyc();
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.rdata0} !== {1'b1, 32'hA000_0001}) begin
            bad++;
            $display("FAIL mid_after_ack got=%h exp=%h", {bus_a.ack0, bus_a.rdata0}, {1'b1, 32'hA000_0001});
        end
    endtask

    // Instance b: both ports held high, port 0 must win every grant.
    task automatic test_fixed_prio();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp();
            total++;
            if ({bus_b.gnt1, bus_b.gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("FAIL fp_gnt k=%0d got=%b exp=%b", k, {bus_b.gnt1, bus_b.gnt0}, ((k % 2 == 0) ? 2'b01 : 2'b00));
            end
            if ((k % 2 == 0) && (k >= 2)) begin
                total++;
                if ({bus_b.ack0, bus_b.ack1, bus_b.rdata0, bus_b.rdata1} !== {2'b10, 32'hA000_0003, 32'h0}) begin
                    bad++;
                    $display("FAIL fp_ack k=%0d got=%h exp=%h", k, {bus_b.ack0, bus_b.ack1, bus_b.rdata0, bus_b.rdata1}, {2'b10, 32'hA000_0003, 32'h0});
                end
            end
            cyc();
        end
        bus_b.req0 = 1'b0;
        smp();
        total++;
        if ({bus_b.gnt1, bus_b.gnt0} !== 2'b10) begin
            bad++;
            $display("FAIL fp_lone_port1 got=%b exp=10", {bus_b.gnt1, bus_b.gnt0});
        end
    endtask

    task automatic test_addr_check();
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_rd206;
`ifdef DMEM_ADDR_CHECK_EN
        exp_err   = 1'b1;
        exp_we    = 1'b0;
        exp_rd206 = 32'h0;
`else
        exp_err   = 1'b0;
        exp_we    = 1'b1;
        exp_rd206 = 32'h55AA_55AA;
`endif
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b1; bus_a.addr0 = 32'd206; bus_a.wdata0 = 32'h55AA_55AA;
        cyc();
        bus_a.req0 = 1'b0;
        smp();
        total++;
        if ({bus_a.mem_we, bus_a.mem_addr} !== {exp_we, 32'd206}) begin
            bad++;
            $display("FAIL chk_wr206_we got=%h exp=%h", {bus_a.mem_we, bus_a.mem_addr}, {exp_we, 32'd206});
        end
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.err0, bus_a.err1} !== {1'b1, exp_err, 1'b0}) begin
            bad++;
            $display("FAIL chk_wr206_err got=%b exp=%b", {bus_a.ack0, bus_a.err0, bus_a.err1}, {1'b1, exp_err, 1'b0});
        end
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd205;
        cyc();
        bus_a.req0 = 1'b0;
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.err0, bus_a.rdata0} !== {2'b10, 32'hA000_00CD}) begin
            bad++;
            $display("FAIL chk_rd205 got=%h exp=%h", {bus_a.ack0, bus_a.err0, bus_a.rdata0}, {2'b10, 32'hA000_00CD});
        end
        cyc();
        bus_a.req0 = 1'b1; bus_a.we0 = 1'b0; bus_a.addr0 = 32'd206;
        cyc();
        bus_a.req0 = 1'b0;
        cyc();
        smp();
        total++;
        if ({bus_a.ack0, bus_a.err0, bus_a.rdata0} !== {1'b1, exp_err, exp_rd206}) begin
            bad++;
            $display("FAIL chk_rd206 got=%h exp=%h", {bus_a.ack0, bus_a.err0, bus_a.rdata0}, {1'b1, exp_err, exp_rd206});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_reset_mid_access();
        test_fixed_prio();
        test_addr_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
